// File: rtl/pe_cfg_loader.sv
// PE array configuration loader: decodes a frame of config words
// into a shadow bank and commits it atomically to the active bank.
module pe_cfg_loader #(
  parameter int M             = 4,
  parameter int N             = 4,
  parameter int N_CFG_BITS_PE = 32,
  parameter int N_PE          = M * N
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [N_CFG_BITS_PE-1:0]     cfg_data_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [$clog2(N_PE)-1:0]      err_pe_idx_o,
  output logic [N_PE*4-1:0]            pe_instr_o,
  output logic [N_PE*4-1:0]            pe_sel_a_o,
  output logic [N_PE*4-1:0]            pe_sel_b_o,
  output logic [N_PE*3-1:0]            pe_dsel_o,
  output logic [N_PE*32-1:0]           pe_const_o
);

  localparam int IW = $clog2(N_PE);

  localparam logic [3:0] SEL_MAX  = 4'd8;
  localparam logic [2:0] DSEL_BAD = 3'd7;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PE - 1);

  typedef logic [3:0] fu_instr_t;
  typedef logic [3:0] pe_mux_sel_t;
  typedef logic [2:0] delay_pe_mux_sel_t;

  typedef struct packed {
    logic [15:0]       cst;
    delay_pe_mux_sel_t dsel;
    pe_mux_sel_t       sel_b;
    pe_mux_sel_t       sel_a;
    fu_instr_t         instr;
  } pe_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT,
    ERROR
  } state_t;

  state_t        state;
  logic [IW-1:0] cnt;

  pe_cfg_t shadow [N_PE];
  pe_cfg_t active [N_PE];

  pe_cfg_t dec;
  logic    illegal;
  logic    accept;
  logic    last;

  // Split the incoming word into its fields and flag illegal encodings
  always_comb begin
    dec       = '0;
    dec.instr = cfg_data_i[3:0];
    dec.sel_a = cfg_data_i[7:4];
    dec.sel_b = cfg_data_i[11:8];
    dec.dsel  = cfg_data_i[14:12];
    dec.cst   = cfg_data_i[31:16];
    illegal   = (dec.sel_a > SEL_MAX)
              | (dec.sel_b > SEL_MAX)
              | (dec.dsel == DSEL_BAD)
              | cfg_data_i[15];
  end

  // Abort in the same cycle as a handshake drops the word
  assign accept = (state == LOAD) & cfg_valid_i
                & cfg_ready_o & ~abort_i;
  assign last   = (cnt == LAST_IDX);

  // Frame sequencing, word counter, error capture, status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      cfg_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      err_pe_idx_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state        <= LOAD;
            cnt          <= '0;
            err_o        <= 1'b0;
            err_pe_idx_o <= '0;
            cfg_ready_o  <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        LOAD: begin
          if (abort_i) begin
            state       <= IDLE;
            cfg_ready_o <= 1'b0;
            busy_o      <= 1'b0;
          end else if (accept) begin
            if (illegal && !err_o) begin
              err_o        <= 1'b1;
              err_pe_idx_o <= cnt;
            end
            if (last) begin
              cfg_ready_o <= 1'b0;
              busy_o      <= 1'b0;
              if (err_o || illegal) begin
                state <= ERROR;
              end else begin
                state  <= COMMIT;
                done_o <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        ERROR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Shadow bank captures each accepted decoded word at its PE slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_PE; k++) begin
        shadow[k] <= '0;
      end
    end else if (accept) begin
      shadow[cnt] <= dec;
    end
  end

  // Active bank takes the whole shadow bank in the commit cycle only
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_PE; k++) begin
        active[k] <= '0;
      end
    end else if (state == COMMIT) begin
      for (int k = 0; k < N_PE; k++) begin
        active[k] <= shadow[k];
      end
    end
  end

  for (genvar k = 0; k < N_PE; k++) begin : g_out
    assign pe_instr_o[4*k +: 4]  = active[k].instr;
    assign pe_sel_a_o[4*k +: 4]  = active[k].sel_a;
    assign pe_sel_b_o[4*k +: 4]  = active[k].sel_b;
    assign pe_dsel_o[3*k +: 3]   = active[k].dsel;
    assign pe_const_o[32*k +: 32] =
      {{16{active[k].cst[15]}}, active[k].cst};
  end

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Randomized self-checking bench for pe_cfg_loader against a
// frame-level model of the active configuration bank.
module tb_pe_cfg_loader;

  localparam int NP = 16;
  localparam int AW = NP*4*3 + NP*3 + NP*32;

  logic clk = 1'b0;
  logic rst, start, abort, cfg_valid;
  logic [31:0] cfg_data;
  logic cfg_ready, busy, done, err;
  logic [3:0] err_idx;
  logic [NP*4-1:0] instr, sel_a, sel_b;
  logic [NP*3-1:0] dsel;
  logic [NP*32-1:0] cst;

  logic [31:0] frame [NP];
  logic [31:0] act_m [NP];
  int n_tests = 0;
  int n_fail  = 0;

  wire [AW-1:0] act_all = {instr, sel_a, sel_b, dsel, cst};

  always #5 clk = ~clk;

  pe_cfg_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .abort_i      (abort),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_data_i   (cfg_data),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .err_pe_idx_o (err_idx),
    .pe_instr_o   (instr),
    .pe_sel_a_o   (sel_a),
    .pe_sel_b_o   (sel_b),
    .pe_dsel_o    (dsel),
    .pe_const_o   (cst)
  );

  function automatic logic [AW-1:0] exp_all();
    logic [NP*4-1:0] i, a, b;
    logic [NP*3-1:0] d;
    logic [NP*32-1:0] c;
    for (int k = 0; k < NP; k++) begin
      i[4*k +: 4] = act_m[k][3:0];
      a[4*k +: 4] = act_m[k][7:4];
      b[4*k +: 4] = act_m[k][11:8];
      d[3*k +: 3] = act_m[k][14:12];
      c[32*k +: 32] = {{16{act_m[k][31]}}, act_m[k][31:16]};
    end
    return {i, a, b, d, c};
  endfunction

  function automatic bit legal(logic [31:0] w);
    return (w[7:4] <= 4'd8) && (w[11:8] <= 4'd8)
        && (w[14:12] != 3'd7) && !w[15];
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    w = $urandom;
    w[7:4]   = 4'($urandom_range(0, 8));
    w[11:8]  = 4'($urandom_range(0, 8));
    w[14:12] = 3'($urandom_range(0, 6));
    w[15]    = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] make_bad(logic [31:0] w0);
    logic [31:0] w;
    w = w0;
    case ($urandom_range(0, 3))
      0: w[7:4]   = 4'($urandom_range(9, 15));
      1: w[11:8]  = 4'($urandom_range(9, 15));
      2: w[14:12] = 3'd7;
      default: w[15] = 1'b1;
    endcase
    return w;
  endfunction

  task automatic rand_frame();
    for (int k = 0; k < NP; k++) frame[k] = rand_legal();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if ({busy, cfg_ready, err} !== 3'b110) begin
      n_fail++;
      $display("FAIL start_state: busy/ready/err=%b want 110",
               {busy, cfg_ready, err});
    end
  endtask

  // Feed n words; optional backpressure, stray starts, abort at a word
  task automatic send_frame(input int nw, input bit bp, input bit rs,
                            input int abort_at, output int hs);
    int cyc;
    bit took;
    hs = 0;
    cyc = 0;
    while (hs < nw && cyc < 4000) begin
      cfg_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_data  = frame[hs];
      start     = rs ? ($urandom_range(0, 3) == 0) : 1'b0;
      abort     = (hs == abort_at) ? cfg_valid : 1'b0;
      took      = cfg_valid && cfg_ready;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      cyc++;
      if (hs == abort_at && took) return;
      if (took) hs++;
      if (hs < NP) begin
        n_tests++;
        if (done !== 1'b0 || act_all !== exp_all()) begin
          n_fail++;
          $display("FAIL load_hold: done=%b at word %0d or active bank changed",
                   done, hs);
        end
      end
    end
    if (hs < nw) begin
      n_fail++;
      $display("FAIL handshake_timeout: got %0d words want %0d", hs, nw);
    end
  endtask

  // Called in the cycle after the last handshake; checks commit/error
  task automatic finish_frame();
    bit ok;
    int first_bad;
    ok = 1'b1;
    first_bad = -1;
    for (int k = 0; k < NP; k++) begin
      if (!legal(frame[k]) && ok) begin
        ok = 1'b0;
        first_bad = k;
      end
    end
    n_tests++;
    if (done !== ok || act_all !== exp_all()) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b want %b (bank must still be old)",
               done, ok);
    end
    if (!ok) begin
      n_tests++;
      if (err !== 1'b1 || err_idx !== 4'(first_bad)) begin
        n_fail++;
        $display("FAIL err_capture: err=%b idx=%0d want 1 idx=%0d",
                 err, err_idx, first_bad);
      end
    end
    @(posedge clk); #1;
    if (ok) for (int k = 0; k < NP; k++) act_m[k] = frame[k];
    n_tests++;
    if (act_all !== exp_all()) begin
      n_fail++;
      $display("FAIL active_bank: got %h want %h", act_all, exp_all());
    end
    n_tests++;
    if ({done, cfg_ready, busy, err} !== {3'b000, !ok}) begin
      n_fail++;
      $display("FAIL post_frame: done/ready/busy/err=%b want %b",
               {done, cfg_ready, busy, err}, {3'b000, !ok});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = '0;
    for (int k = 0; k < NP; k++) act_m[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({cfg_ready, busy, done, err, err_idx} !== 8'd0 ||
        act_all !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b err=%b idx=%0d",
               cfg_ready, busy, done, err, err_idx);
    end
  endtask

  task automatic test_full_frame();
    int hs;
    for (int k = 0; k < NP; k++) begin
      logic [15:0] cv;
      cv = 16'(k - 8);
      frame[k] = {cv, 1'b0, 3'd4, 4'd6, 4'd3, 4'hA};
    end
    do_start();
    send_frame(NP, 1'b0, 1'b0, -1, hs);
    finish_frame();
    n_tests++;
    if (cst[31:0] !== 32'hFFFFFFF8 || cst[511:480] !== 32'h00000007) begin
      n_fail++;
      $display("FAIL const_ext: pe0=%h pe15=%h want fffffff8 00000007",
               cst[31:0], cst[511:480]);
    end
    n_tests++;
    if (instr !== {16{4'hA}} || sel_a !== {16{4'h3}} ||
        sel_b !== {16{4'h6}} || dsel !== {16{3'd4}}) begin
      n_fail++;
      $display("FAIL full_fields: instr=%h sel_a=%h sel_b=%h dsel=%h",
               instr, sel_a, sel_b, dsel);
    end
  endtask

  task automatic test_backpressure();
    int hs;
    logic [31:0] pat [NP];
    for (int k = 0; k < NP; k++) pat[k] = frame[k];
    rand_frame();
    do_start();
    send_frame(NP, 1'b1, 1'b0, -1, hs);
    finish_frame();
    for (int k = 0; k < NP; k++) frame[k] = pat[k];
    do_start();
    send_frame(NP, 1'b1, 1'b0, -1, hs);
    n_tests++;
    if (hs !== NP) begin
      n_fail++;
      $display("FAIL bp_handshakes: got %0d want %0d", hs, NP);
    end
    finish_frame();
  endtask

  task automatic test_illegal();
    int hs;
    rand_frame();
    frame[5][7:4] = 4'd9;
    frame[9][15] = 1'b1;
    do_start();
    send_frame(NP, 1'b0, 1'b0, -1, hs);
    finish_frame();
    do_start();
    rand_frame();
    send_frame(NP, 1'b1, 1'b0, -1, hs);
    finish_frame();
  endtask

  task automatic test_abort();
    int hs;
    rand_frame();
    do_start();
    send_frame(NP, 1'b0, 1'b0, 7, hs);
    n_tests++;
    if (hs !== 7 || {busy, cfg_ready, done} !== 3'b000 ||
        act_all !== exp_all()) begin
      n_fail++;
      $display("FAIL abort: words=%0d busy/ready/done=%b want 7 000",
               hs, {busy, cfg_ready, done});
    end
    @(posedge clk); #1;
    n_tests++;
    if (act_all !== exp_all() || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold: ready=%b want 0, bank must be unchanged",
               cfg_ready);
    end
    rand_frame();
    do_start();
    send_frame(NP, 1'b0, 1'b0, -1, hs);
    finish_frame();
  endtask

  task automatic test_ignored_start();
    int hs;
    rand_frame();
    do_start();
    send_frame(NP, 1'b1, 1'b1, -1, hs);
    finish_frame();
  endtask

  task automatic test_reset_mid();
    int hs;
    rand_frame();
    do_start();
    send_frame(11, 1'b0, 1'b0, -1, hs);
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NP; k++) act_m[k] = '0;
    n_tests++;
    if ({cfg_ready, busy, done, err, err_idx} !== 8'd0 ||
        act_all !== exp_all()) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b busy=%b done=%b err=%b idx=%0d",
               cfg_ready, busy, done, err, err_idx);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    rand_frame();
    do_start();
    send_frame(NP, 1'b0, 1'b0, -1, hs);
    finish_frame();
  endtask

  task automatic test_random();
    int hs;
    for (int f = 0; f < 8; f++) begin
      rand_frame();
      if ($urandom_range(0, 2) == 0) begin
        int nb;
        nb = $urandom_range(1, 3);
        for (int j = 0; j < nb; j++) begin
          int p;
          p = $urandom_range(0, NP - 1);
          frame[p] = make_bad(frame[p]);
        end
      end
      do_start();
      send_frame(NP, 1'($urandom_range(0, 1)), 1'b0, -1, hs);
      finish_frame();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_illegal();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
